// File: rtl/supervise_pkg.sv
// supervise_pkg: shared types and helpers for the supervise training initiator.
//   state_t     - controller states
//   ACT_HI_DEF  - default activation output for a non-negative neuron result
//   act_fire()  - hard-threshold decision on the result sign bit
package supervise_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_RES,
    S_ERR,
    S_FBK,
    S_EVAL
  } state_t;

  localparam logic [15:0] ACT_HI_DEF = 16'h00ff;

  // Neuron "fires" when its signed result is non-negative.
  function automatic logic act_fire(input logic res_sign);
    return ~res_sign;
  endfunction

endpackage

// File: rtl/supervise_table.sv
// supervise_table: N-entry sample register file.
//   clk      - clock
//   we_i     - write strobe
//   waddr_i  - write index
//   wdata_i  - write data ({argument, target})
//   raddr_i  - read index
//   rdata_o  - asynchronous read data
// Contents are deliberately not reset.
module supervise_table #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/supervise.sv
// supervise: training initiator for one associate neuron.
// Streams table arguments to the neuron, thresholds its results, returns the
// error and swallows the feedback for a programmed number of epochs (en=1),
// then runs one evaluation pass (en=0) counting misclassified samples.
//   clk, rst (async, active low)
//   smp_we/smp_addr/smp_arg/smp_tgt - sample table write port (IDLE only)
//   start/epochs                    - run request and epoch count
//   en                              - neuron training enable
//   arg_*, res_*, err_*, fbk_*      - valid/ready streams to/from the neuron
//   busy, done, misses              - run status
// Optional: define SUPERVISE_EARLY_STOP_EN to end training after the first
// epoch in which every sample was classified correctly.
module supervise
  import supervise_pkg::*;
#(
  parameter int ARGW = 8,
  parameter int ARGD = 2,
  parameter int RESW = 16,
  parameter int ERRW = 16,
  parameter int FBKW = 16,
  parameter int FBKD = 2,
  parameter int N    = 4,
  parameter int EPW  = 8,
  parameter logic [RESW-1:0] ACT_HI = RESW'(ACT_HI_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 smp_we,
  input  logic [$clog2(N)-1:0] smp_addr,
  input  logic [ARGD*ARGW-1:0] smp_arg,
  input  logic [RESW-1:0]      smp_tgt,
  input  logic                 start,
  input  logic [EPW-1:0]       epochs,
  output logic                 en,
  output logic [ARGD*ARGW-1:0] arg_data,
  output logic                 arg_valid,
  input  logic                 arg_ready,
  input  logic [RESW-1:0]      res_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  output logic [ERRW-1:0]      err_data,
  output logic                 err_valid,
  input  logic                 err_ready,
  input  logic [FBKD*FBKW-1:0] fbk_data,
  input  logic                 fbk_valid,
  output logic                 fbk_ready,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N):0]   misses
);

  localparam int AW = $clog2(N);
  localparam int MW = AW + 1;
  localparam int TW = ARGD * ARGW + RESW;
  localparam int DW = (ERRW > RESW) ? ERRW : RESW;
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

  state_t          state_q;
  logic [AW-1:0]   idx_q;
  logic [EPW-1:0]  epoch_q, ep_lim_q;
  logic [MW-1:0]   misses_q;
  logic [ERRW-1:0] err_q;
  logic            en_q, busy_q, done_q;
  logic            arg_valid_q, res_ready_q, err_valid_q, fbk_ready_q;

  logic [TW-1:0]   rd_w;
  logic [RESW-1:0] tgt_w, act_w;
  logic [DW-1:0]   diff_w;
  logic [ERRW-1:0] err_d;
  logic            train_end;
  logic            unused_fbk;

  supervise_table #(.W(TW), .N(N), .AW(AW)) u_table (
    .clk     (clk),
    .we_i    (smp_we && (state_q == S_IDLE)),
    .waddr_i (smp_addr),
    .wdata_i ({smp_arg, smp_tgt}),
    .raddr_i (idx_q),
    .rdata_o (rd_w)
  );

  assign tgt_w  = rd_w[RESW-1:0];
  assign act_w  = act_fire(res_data[RESW-1]) ? ACT_HI : '0;
  // Target is signed and sign-extends; the activation is never negative.
  assign diff_w = DW'($signed(tgt_w)) - DW'(act_w);
  assign err_d  = diff_w[ERRW-1:0];

  // Feedback content is irrelevant to the initiator; it is only consumed.
  assign unused_fbk = ^fbk_data;

`ifdef SUPERVISE_EARLY_STOP_EN
  // Only "any miss this epoch" matters for stopping, so a flag suffices.
  logic ep_miss_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ep_miss_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      ep_miss_q <= 1'b0;
    end else if (state_q == S_RES && res_valid && en_q && err_d != '0) begin
      ep_miss_q <= 1'b1;
    end else if (state_q == S_FBK && fbk_valid && idx_q == IDX_LAST) begin
      ep_miss_q <= 1'b0;
    end
  end

  assign train_end = ((epoch_q + EPW'(1)) == ep_lim_q) || !ep_miss_q;
`else
  assign train_end = (epoch_q + EPW'(1)) == ep_lim_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      epoch_q     <= '0;
      ep_lim_q    <= '0;
      misses_q    <= '0;
      err_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arg_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
      err_valid_q <= 1'b0;
      fbk_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ep_lim_q <= epochs;
            idx_q    <= '0;
            epoch_q  <= '0;
            busy_q   <= 1'b1;
            if (epochs == '0) begin
              state_q <= S_EVAL;
            end else begin
              en_q        <= 1'b1;
              arg_valid_q <= 1'b1;
              state_q     <= S_ARG;
            end
          end
        end
        S_ARG: begin
          if (arg_ready) begin
            arg_valid_q <= 1'b0;
            res_ready_q <= 1'b1;
            state_q     <= S_RES;
          end
        end
        S_RES: begin
          if (res_valid) begin
            res_ready_q <= 1'b0;
            err_q       <= err_d;
            if (en_q) begin
              err_valid_q <= 1'b1;
              state_q     <= S_ERR;
            end else begin
              if (err_d != '0 && misses_q != MW'(N)) misses_q <= misses_q + MW'(1);
              if (idx_q == IDX_LAST) begin
                idx_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                idx_q       <= idx_q + AW'(1);
                arg_valid_q <= 1'b1;
                state_q     <= S_ARG;
              end
            end
          end
        end
        S_ERR: begin
          if (err_ready) begin
            err_valid_q <= 1'b0;
            fbk_ready_q <= 1'b1;
            state_q     <= S_FBK;
          end
        end
        S_FBK: begin
          if (fbk_valid) begin
            fbk_ready_q <= 1'b0;
            idx_q       <= idx_q + AW'(1);
            if (idx_q == IDX_LAST) begin
              epoch_q <= epoch_q + EPW'(1);
              if (train_end) begin
                en_q     <= 1'b0;
                misses_q <= '0;
                state_q  <= S_EVAL;
              end else begin
                arg_valid_q <= 1'b1;
                state_q     <= S_ARG;
              end
            end else begin
              arg_valid_q <= 1'b1;
              state_q     <= S_ARG;
            end
          end
        end
        // One-cycle setup for the evaluation pass.
        S_EVAL: begin
          idx_q       <= '0;
          misses_q    <= '0;
          arg_valid_q <= 1'b1;
          state_q     <= S_ARG;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misses    = misses_q;
  assign arg_data  = rd_w[TW-1:RESW];
  assign arg_valid = arg_valid_q;
  assign res_ready = res_ready_q;
  assign err_data  = err_q;
  assign err_valid = err_valid_q;
  assign fbk_ready = fbk_ready_q;

endmodule

// File: tb/tb_supervise.sv
module tb_supervise;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        smp_we = 1'b0;
  logic [1:0]  smp_addr = '0;
  logic [15:0] smp_arg = '0;
  logic [15:0] smp_tgt = '0;
  logic        start = 1'b0;
  logic [7:0]  epochs = '0;
  logic        en;
  logic [15:0] arg_data;
  logic        arg_valid;
  logic        arg_ready = 1'b0;
  logic [15:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [15:0] err_data;
  logic        err_valid;
  logic        err_ready = 1'b0;
  logic [31:0] fbk_data = 32'h1357_9bdf;
  logic        fbk_valid = 1'b0;
  logic        fbk_ready;
  logic        busy;
  logic        done;
  logic [2:0]  misses;

  supervise dut (
    .clk(clk), .rst(rst),
    .smp_we(smp_we), .smp_addr(smp_addr), .smp_arg(smp_arg), .smp_tgt(smp_tgt),
    .start(start), .epochs(epochs), .en(en),
    .arg_data(arg_data), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .err_data(err_data), .err_valid(err_valid), .err_ready(err_ready),
    .fbk_data(fbk_data), .fbk_valid(fbk_valid), .fbk_ready(fbk_ready),
    .busy(busy), .done(done), .misses(misses)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stub neuron and transfer monitor.
  bit          stall = 1'b0;
  logic [15:0] res_val = '0;
  int n_arg, n_err, n_err_en, n_fbk, n_done, n_en_cyc;
  logic [15:0] arg_log[$];
  logic [15:0] err_log[$];
  bit          res_fire = 1'b0, fbk_fire = 1'b0;
  bit          arg_hold = 1'b0, err_hold = 1'b0;
  logic [15:0] arg_prev, err_prev;

  always @(negedge clk) begin
    if (res_fire) res_valid = 1'b0;
    if (fbk_fire) fbk_valid = 1'b0;
    res_fire  = 1'b0;
    fbk_fire  = 1'b0;
    arg_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    err_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!res_valid) res_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (!fbk_valid) fbk_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    res_data = res_val;
    #1;
    if (!rst) begin
      arg_hold = 1'b0;
      err_hold = 1'b0;
    end else begin
      if (arg_hold) begin
        chk("arg_valid_hold", arg_valid, 1);
        chk("arg_stable", arg_data, arg_prev);
      end
      if (err_hold) begin
        chk("err_valid_hold", err_valid, 1);
        chk("err_stable", err_data, err_prev);
      end
      arg_hold = arg_valid && !arg_ready;
      arg_prev = arg_data;
      err_hold = err_valid && !err_ready;
      err_prev = err_data;
      if (arg_valid && arg_ready) begin n_arg++; arg_log.push_back(arg_data); end
      if (err_valid && err_ready) begin
        n_err++;
        err_log.push_back(err_data);
        if (en) n_err_en++;
      end
      if (res_valid && res_ready) res_fire = 1'b1;
      if (fbk_valid && fbk_ready) begin fbk_fire = 1'b1; n_fbk++; end
      if (done) n_done++;
      if (en) n_en_cyc++;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] arg, input logic [15:0] tgt);
    smp_we = 1'b1; smp_addr = a; smp_arg = arg; smp_tgt = tgt;
    @(negedge clk);
    smp_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] t0, input logic [15:0] t1,
                      input logic [15:0] t2, input logic [15:0] t3);
    wr(0, 16'h0000, t0);
    wr(1, 16'h00ff, t1);
    wr(2, 16'hff00, t2);
    wr(3, 16'hffff, t3);
  endtask

  task automatic kick(input logic [7:0] ep);
    n_arg = 0; n_err = 0; n_err_en = 0; n_fbk = 0; n_done = 0; n_en_cyc = 0;
    arg_log.delete();
    err_log.delete();
    start = 1'b1; epochs = ep;
    @(negedge clk);
    start = 1'b0; smp_we = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (n_done == 0 && cyc < 2000) begin
      @(negedge clk); #2;
      cyc++;
    end
    chk("run_done", n_done != 0, 1);
    repeat (3) @(negedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", en, 0);
    chk("rst_misses", misses, 0);
    chk("rst_arg_valid", arg_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_fbk_ready", fbk_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // A: eval only, AND table, neuron always negative; entry 0 rewritten with start.
    load(16'h0055, 16'h0000, 16'h0000, 16'h00ff);
    wr(0, 16'h1234, 16'h0055);
    res_val = 16'hffff;
    smp_we = 1'b1; smp_addr = 0; smp_arg = 16'h0000; smp_tgt = 16'h0000;
    kick(8'd0);
    wait_done();
    chk("A_n_arg", n_arg, 4);
    chk("A_n_err", n_err, 0);
    chk("A_en_cycles", n_en_cyc, 0);
    chk("A_misses", misses, 1);
    chk("A_done_pulses", n_done, 1);
    chk("A_busy_after", busy, 0);
    chk("A_arg0_new", arg_log[0], 16'h0000);
    chk("A_arg3", arg_log[3], 16'hffff);

    // B: one epoch, targets all 00ff, neuron positive -> zero error.
    load(16'h00ff, 16'h00ff, 16'h00ff, 16'h00ff);
    res_val = 16'h0001;
    kick(8'd1);
    wait_done();
    chk("B_n_arg", n_arg, 8);
    chk("B_n_err", n_err, 4);
    chk("B_n_fbk", n_fbk, 4);
    chk("B_en_during_err", n_err_en, 4);
    chk("B_err0", err_log[0], 16'h0000);
    chk("B_err3", err_log[3], 16'h0000);
    chk("B_misses", misses, 0);
    chk("B_en_after", en, 0);

    // C1: result 8000 is negative -> act 0 -> err 00ff; every sample missed.
    res_val = 16'h8000;
    kick(8'd1);
    wait_done();
    chk("C1_err0", err_log[0], 16'h00ff);
    chk("C1_err3", err_log[3], 16'h00ff);
    chk("C1_misses_sat", misses, 4);

    // C2: result 0 is non-negative -> act 00ff, target 0 -> err ff01.
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    res_val = 16'h0000;
    kick(8'd1);
    wait_done();
    chk("C2_err0", err_log[0], 16'hff01);
    chk("C2_err2", err_log[2], 16'hff01);
    chk("C2_misses", misses, 4);

    // D: random stalls, two epochs, AND table; a table write while busy is ignored.
    load(16'h0000, 16'h0000, 16'h0000, 16'h00ff);
    res_val = 16'h0001;
    stall = 1'b1;
    kick(8'd2);
    wr(3, 16'h0000, 16'h0000);
    wait_done();
    chk("D_n_arg", n_arg, 12);
    chk("D_n_err", n_err, 8);
    chk("D_n_fbk", n_fbk, 8);
    chk("D_err2", err_log[2], 16'hff01);
    chk("D_err3", err_log[3], 16'h0000);
    chk("D_err7", err_log[7], 16'h0000);
    chk("D_arg_last", arg_log[11], 16'hffff);
    chk("D_misses", misses, 3);

    // E: reset while waiting for a result, then restart from sample 0.
    kick(8'd3);
    begin
      int cyc = 0;
      while (!res_ready && cyc < 200) begin
        @(negedge clk); #2;
        cyc++;
      end
    end
    chk("E_reach_res", res_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("E_arg_valid", arg_valid, 0);
    chk("E_res_ready", res_ready, 0);
    chk("E_err_valid", err_valid, 0);
    chk("E_fbk_ready", fbk_ready, 0);
    chk("E_busy", busy, 0);
    chk("E_en", en, 0);
    chk("E_misses", misses, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    res_val = 16'hffff;
    @(negedge clk);
    kick(8'd0);
    wait_done();
    chk("E_restart_arg0", arg_log[0], 16'h0000);
    chk("E_restart_n_arg", n_arg, 4);
    chk("E_restart_misses", misses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
